// File: rtl/mult_share_arb.sv
// Round-robin front end sharing one signed Booth multiplier core among R requesters,
// with a watchdog that aborts an operation whose core never reports completion.
module mult_share_arb #(
  parameter int N   = 4,
  parameter int R   = 4,
  parameter int TMO = 4*N+8,
  parameter int IDW = $clog2(R)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     req_valid,
  input  logic [R*N-1:0]   req_a,
  input  logic [R*N-1:0]   req_b,
  output logic [R-1:0]     req_ready,
  output logic             resp_valid,
  output logic [IDW-1:0]   resp_id,
  output logic [2*N-1:0]   resp_result,
  output logic             resp_err,
  input  logic             resp_ready,
  output logic [N-1:0]     mul_multiplicand,
  output logic [N-1:0]     mul_multiplier,
  output logic             mul_start,
  input  logic             mul_in_process,
  input  logic             mul_finish,
  input  logic [2*N-1:0]   mul_result,
  output logic             busy
);
  localparam int unsigned RU = R;
  localparam int CW = $clog2(TMO+1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RUN, WAIT_DONE, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] cand;
  logic           pick_ok;
  logic [CW-1:0]  wd_cnt;
  logic           wd_expired;
  int unsigned    idx;

  // Search starts one past the last served requester and wraps around.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= RU; k++) begin
      idx = 32'(last) + k;
      if (idx >= RU) idx = idx - RU;
      cand = IDW'(idx);
      if (!pick_ok && req_valid[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  // The accept pulse must coincide with the grant decision, so it is decoded
  // from the state register rather than registered itself.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && pick_ok && !rst) req_ready[pick] = 1'b1;
  end

  assign wd_expired = (wd_cnt == CW'(TMO-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      last             <= IDW'(R-1);
      resp_id          <= '0;
      resp_result      <= '0;
      resp_err         <= 1'b0;
      resp_valid       <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      mul_start        <= 1'b0;
      busy             <= 1'b0;
      wd_cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_ok) begin
            resp_id          <= pick;
            resp_err         <= 1'b0;
            mul_multiplicand <= req_a[pick*N +: N];
            mul_multiplier   <= req_b[pick*N +: N];
            mul_start        <= 1'b1;
            busy             <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start <= 1'b0;
          wd_cnt    <= '0;
          state     <= WAIT_RUN;
        end
        WAIT_RUN: begin
          // A sticky finish from the previous operation is deliberately ignored here.
          if (wd_expired) begin
            resp_result <= '0;
            resp_err    <= 1'b1;
            resp_valid  <= 1'b1;
            state       <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (mul_in_process) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!mul_in_process && mul_finish) begin
            resp_result <= mul_result;
            resp_err    <= 1'b0;
            resp_valid  <= 1'b1;
            state       <= RESP;
          end else if (wd_expired) begin
            resp_result <= '0;
            resp_err    <= 1'b1;
            resp_valid  <= 1'b1;
            state       <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid       <= 1'b0;
            busy             <= 1'b0;
            last             <= resp_id;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: a behavioural multiplier core, a transaction-level
// reference model checked every cycle, and directed scenarios with literal results.
module tb_mult_share_arb;
  localparam int N   = 4;
  localparam int R   = 4;
  localparam int TMO = 4*N+8;
  localparam int IDW = $clog2(R);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [R-1:0]     req_valid = '0;
  logic [R*N-1:0]   req_a = '0;
  logic [R*N-1:0]   req_b = '0;
  logic [R-1:0]     req_ready;
  logic             resp_valid;
  logic [IDW-1:0]   resp_id;
  logic [2*N-1:0]   resp_result;
  logic             resp_err;
  logic             resp_ready = 1'b1;
  logic [N-1:0]     mul_multiplicand;
  logic [N-1:0]     mul_multiplier;
  logic             mul_start;
  logic             mul_in_process = 1'b0;
  logic             mul_finish = 1'b0;
  logic [2*N-1:0]   mul_result = '0;
  logic             busy;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 0;

  mult_share_arb #(.N(N), .R(R), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_result(resp_result), .resp_err(resp_err), .resp_ready(resp_ready),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_start(mul_start), .mul_in_process(mul_in_process), .mul_finish(mul_finish),
    .mul_result(mul_result), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
    int x;
    int y;
    x = $signed(a);
    y = $signed(b);
    return 8'(x * y);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural core: optional start delay (stale finish stays visible), fixed run time, stuck mode.
  int   core_dly = 0;
  int   core_run = 4;
  bit   core_stuck = 0;
  logic [3:0] c_a, c_b;
  int   c_wait, c_left;
  bit   c_act = 0;

  always @(posedge clk) begin
    if (mul_start) begin
      c_a    <= mul_multiplicand;
      c_b    <= mul_multiplier;
      c_wait <= core_dly;
      c_left <= core_run;
      c_act  <= 1'b1;
      if (core_dly == 0) begin
        mul_in_process <= 1'b1;
        mul_finish     <= 1'b0;
      end
    end else if (c_act) begin
      if (c_wait > 0) begin
        c_wait <= c_wait - 1;
        if (c_wait == 1) begin
          mul_in_process <= 1'b1;
          mul_finish     <= 1'b0;
        end
      end else if (!core_stuck) begin
        c_left <= c_left - 1;
        if (c_left == 1) begin
          mul_in_process <= 1'b0;
          mul_finish     <= 1'b1;
          mul_result     <= prod(c_a, c_b);
          c_act          <= 1'b0;
        end
      end
    end
  end

  // Transaction-level reference model.
  bit         m_busy = 0, m_start = 0, m_wait = 0, m_run = 0, m_resp = 0, m_err = 0;
  int         m_k = 0, m_last = R-1, m_id = 0;
  logic [3:0] m_a = '0, m_b = '0;
  logic [7:0] m_res = '0;
  int         g_log[$];
  int         r_id[$];
  logic [7:0] r_res[$];
  bit         r_err[$];

  always @(negedge clk) begin
    int pick;
    int i;
    logic [R-1:0] exp_rdy;
    pick = -1;
    if (!m_busy && !rst)
      for (int k = 1; k <= R; k++) begin
        i = (m_last + k) % R;
        if (pick < 0 && req_valid[i]) pick = i;
      end
    exp_rdy = '0;
    if (pick >= 0) exp_rdy[pick] = 1'b1;
    if (chk_en) begin
      chk("req_ready", req_ready, exp_rdy);
      chk("mul_start", mul_start, m_start);
      chk("busy", busy, m_busy);
      chk("resp_valid", resp_valid, m_resp);
      if (m_resp) begin
        chk("resp_id", resp_id, m_id);
        chk("resp_result", resp_result, m_res);
        chk("resp_err", resp_err, m_err);
      end
      if (m_busy && !m_resp) begin
        chk("op_a_hold", mul_multiplicand, m_a);
        chk("op_b_hold", mul_multiplier, m_b);
      end
      if (!m_busy) begin
        chk("op_a_idle", mul_multiplicand, 0);
        chk("op_b_idle", mul_multiplier, 0);
      end
      if (mul_start) chk("start_vs_inproc", mul_in_process, 0);
    end
    if (rst) begin
      m_busy = 0; m_start = 0; m_wait = 0; m_run = 0; m_resp = 0; m_last = R-1;
    end else if (!m_busy) begin
      if (pick >= 0) begin
        m_busy = 1; m_start = 1; m_id = pick;
        m_a = req_a[pick*N +: N];
        m_b = req_b[pick*N +: N];
        g_log.push_back(pick);
      end
    end else if (m_start) begin
      m_start = 0; m_wait = 1; m_k = 0; m_run = 0;
    end else if (m_wait) begin
      m_k++;
      if (m_run && !mul_in_process && mul_finish) begin
        m_wait = 0; m_resp = 1; m_res = prod(m_a, m_b); m_err = 0;
      end else if (m_k == TMO) begin
        m_wait = 0; m_resp = 1; m_res = '0; m_err = 1;
      end else if (mul_in_process) begin
        m_run = 1;
      end
    end else if (m_resp && resp_ready) begin
      r_id.push_back(m_id); r_res.push_back(m_res); r_err.push_back(m_err);
      m_busy = 0; m_resp = 0; m_last = m_id;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    int n0;
    int t;
    n0 = g_log.size();
    t  = 0;
    while (g_log.size() == n0 && t < 200) begin tick(); t++; end
    chk("grant_seen", g_log.size(), n0 + 1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    int t;
    t = 0;
    while (r_id.size() < n && t < 300) begin tick(); t++; end
    chk("resp_seen", r_id.size(), n);
  endtask

  task automatic chk_resp(input string nm, input int n, input int id, input logic [7:0] res, input bit err);
    if (r_id.size() >= n) begin
      chk({nm, "_id"}, r_id[n-1], id);
      chk({nm, "_res"}, r_res[n-1], res);
      chk({nm, "_err"}, r_err[n-1], err);
    end else begin
      chk({nm, "_missing"}, r_id.size(), n);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_req_ready"}, req_ready, 0);
    chk({nm, "_mul_start"}, mul_start, 0);
    chk({nm, "_resp_valid"}, resp_valid, 0);
    chk({nm, "_resp_err"}, resp_err, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_resp_id"}, resp_id, 0);
    chk({nm, "_resp_result"}, resp_result, 0);
    chk({nm, "_ops"}, {mul_multiplicand, mul_multiplier}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    chk_en = 1;
    tick();
    rst = 1'b0;
    chk_reset_vals("reset");

    // All four requesters held valid: grants rotate 0,1,2,3,0.
    core_dly = 1;
    set_req(0, 4'h1, 4'h2);
    set_req(1, 4'h3, 4'hE);
    set_req(2, 4'h5, 4'h5);
    set_req(3, 4'h8, 4'h7);
    wait_resp(5);
    req_valid = '0;
    if (g_log.size() >= 5) begin
      chk("rr_g0", g_log[0], 0);
      chk("rr_g1", g_log[1], 1);
      chk("rr_g2", g_log[2], 2);
      chk("rr_g3", g_log[3], 3);
      chk("rr_g4", g_log[4], 0);
    end
    chk_resp("rr0", 1, 0, 8'h02, 1'b0);
    chk_resp("rr1", 2, 1, 8'hFA, 1'b0);
    chk_resp("rr2", 3, 2, 8'h19, 1'b0);
    chk_resp("rr3", 4, 3, 8'hC8, 1'b0);
    chk_resp("rr4", 5, 0, 8'h02, 1'b0);
    core_dly = 0;
    tick(); tick();

    set_req(0, 4'h7, 4'h7);
    wait_grant(0);
    wait_resp(6);
    chk_resp("single", 6, 0, 8'h31, 1'b0);

    // Delayed core start leaves the previous finish visible during WAIT_RUN.
    core_dly = 2;
    set_req(2, 4'hD, 4'h5);
    wait_grant(2);
    wait_resp(7);
    chk_resp("signed", 7, 2, 8'hF1, 1'b0);
    core_dly = 0;

    resp_ready = 1'b0;
    set_req(1, 4'h3, 4'h3);
    wait_grant(1);
    for (int t = 0; t < 100 && !resp_valid; t++) tick();
    chk("bp_valid", resp_valid, 1);
    set_req(3, 4'h2, 4'hF);
    repeat (10) tick();
    chk("bp_not_accepted", r_id.size(), 7);
    resp_ready = 1'b1;
    wait_grant(3);
    wait_resp(9);
    chk_resp("bp", 8, 1, 8'h09, 1'b0);
    chk_resp("bp_next", 9, 3, 8'hFE, 1'b0);

    core_stuck = 1;
    set_req(0, 4'h1, 4'h1);
    wait_grant(0);
    wait_resp(10);
    chk_resp("wdog", 10, 0, 8'h00, 1'b1);
    core_stuck = 0;
    repeat (12) tick();
    set_req(2, 4'h6, 4'h2);
    wait_grant(2);
    wait_resp(11);
    chk_resp("after_wdog", 11, 2, 8'h0C, 1'b0);

    core_run = 8;
    set_req(1, 4'h5, 4'h3);
    wait_grant(1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("midrst");
    core_run = 4;
    repeat (12) tick();
    chk("midrst_no_resp", r_id.size(), 11);
    set_req(1, 4'h2, 4'h3);
    wait_grant(1);
    wait_resp(12);
    chk_resp("post_rst", 12, 1, 8'h06, 1'b0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
